// File: rtl/sm_bec_ladder.sv
// sm_bec_ladder: Montgomery-ladder sequencer for binary Edwards curve scalar
// multiplication over GF(2^M). Walks the scalar MSB-first and issues seven field
// operations per key bit to an external ACB over a start/done handshake. The
// projective ladder state (A,B,C,D) lives here; (wout,zout) = (A,B) at the end.
//
// Optional build macro: BEC_CSWAP_EN -- constant-time datapath. A mask-XOR
// conditional swap runs before and after each bit (SWIN/SWOUT), so operand
// selection never depends on the key bit.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start, abort          begin multiplication (IDLE only) / return to IDLE
//   k                     scalar, captured on accepted start
//   w1, z1, w2, z2        initial ladder points, captured on accepted start
//   inv_w0, d             curve constants, stable while busy
//   acb_start             one-cycle operation request
//   acb_a, acb_b, acb_cfg operands and mode (0 = multiply, 1 = mode 1)
//   acb_done, acb_c       result strobe and result
//   busy                  high from LOAD through the last bit
//   bit_done, done        per-bit and completion pulses
//   wout, zout            result, held until next accepted start or abort
module sm_bec_ladder #(
    parameter int unsigned M        = 163,
    parameter int unsigned KEY_BITS = 163
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [KEY_BITS-1:0] k,
    input  logic [M-1:0]        w1,
    input  logic [M-1:0]        z1,
    input  logic [M-1:0]        w2,
    input  logic [M-1:0]        z2,
    input  logic [M-1:0]        inv_w0,
    input  logic [M-1:0]        d,
    output logic                acb_start,
    output logic [M-1:0]        acb_a,
    output logic [M-1:0]        acb_b,
    output logic                acb_cfg,
    input  logic                acb_done,
    input  logic [M-1:0]        acb_c,
    output logic                busy,
    output logic                bit_done,
    output logic                done,
    output logic [M-1:0]        wout,
    output logic [M-1:0]        zout
);

    localparam int unsigned   CW      = $clog2(KEY_BITS + 1);
    localparam int unsigned   OW      = 3;
    localparam logic [OW-1:0] OP_LAST = OW'(6);
    localparam logic [CW-1:0] CNT_END = CW'(KEY_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
`ifdef BEC_CSWAP_EN
        ,
        S_SWIN  = 3'd6,
        S_SWOUT = 3'd7
`endif
    } state_t;

    state_t              state, state_nx;
    logic [KEY_BITS-1:0] ks, ks_nx;
    logic [M-1:0]        ra, rb, rc, rd;
    logic [M-1:0]        ra_nx, rb_nx, rc_nx, rd_nx;
    logic [OW-1:0]       op, op_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [M-1:0]        wout_nx, zout_nx;
    logic                busy_nx, bit_done_nx, done_nx;
    logic                start_nx, cfg_nx;
    logic [M-1:0]        a_nx, b_nx;
    logic                ki, map_ki, map_ki_nx;
    logic [M-1:0]        wx, wy, wu, wv;
    logic [M-1:0]        nx_x, nx_y, nx_u, nx_v;

    // Role mapping (A,B,C,D) -> (X,Y,U,V); it is its own inverse.
    function automatic logic [4*M-1:0] to_roles(input logic kb, input logic [M-1:0] a,
                                                input logic [M-1:0] b, input logic [M-1:0] c,
                                                input logic [M-1:0] e);
        return kb ? {a, b, c, e} : {c, e, a, b};
    endfunction

    assign ki = ks[KEY_BITS-1];

`ifdef BEC_CSWAP_EN
    logic [M-1:0] swap_mask, t_ac, t_bd;

    // Fixed roles; the key bit only enters through the swap mask.
    assign map_ki    = 1'b1;
    assign map_ki_nx = 1'b1;
    assign swap_mask = {M{~ki}};
    assign t_ac      = (ra ^ rc) & swap_mask;
    assign t_bd      = (rb ^ rd) & swap_mask;
`else
    assign map_ki    = ki;
    assign map_ki_nx = ks_nx[KEY_BITS-1];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, ladder write-back and status outputs
    always_comb begin
        state_nx = state;
        ks_nx    = ks;
        ra_nx    = ra;
        rb_nx    = rb;
        rc_nx    = rc;
        rd_nx    = rd;
        op_nx    = op;
        cnt_nx   = cnt;
        wout_nx  = wout;
        zout_nx  = zout;
        {wx, wy, wu, wv} = to_roles(map_ki, ra, rb, rc, rd);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                    ks_nx    = k;
                    ra_nx    = w1;
                    rb_nx    = z1;
                    rc_nx    = w2;
                    rd_nx    = z2;
                    wout_nx  = '0;
                    zout_nx  = '0;
                end
            end
            S_LOAD: begin
                op_nx  = '0;
                cnt_nx = '0;
`ifdef BEC_CSWAP_EN
                state_nx = S_SWIN;
`else
                state_nx = S_ISSUE;
`endif
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (acb_done) begin
                    case (op)
                        3'd0:    wx = acb_c;
                        3'd1:    wx = wx ^ acb_c;
                        3'd2:    wy = acb_c;
                        3'd3: begin
                            wx = wx ^ acb_c;
                            wy = wy ^ acb_c;
                        end
                        3'd4:    wu = acb_c;
                        3'd5:    wv = acb_c;
                        default: wv = wu ^ acb_c;
                    endcase
                    {ra_nx, rb_nx, rc_nx, rd_nx} = to_roles(map_ki, wx, wy, wu, wv);
                    if (op == OP_LAST) begin
`ifdef BEC_CSWAP_EN
                        state_nx = S_SWOUT;
`else
                        state_nx = S_NEXT;
`endif
                    end else begin
                        op_nx    = op + OW'(1);
                        state_nx = S_ISSUE;
                    end
                end
            end
`ifdef BEC_CSWAP_EN
            S_SWIN, S_SWOUT: begin
                ra_nx    = ra ^ t_ac;
                rc_nx    = rc ^ t_ac;
                rb_nx    = rb ^ t_bd;
                rd_nx    = rd ^ t_bd;
                state_nx = (state == S_SWIN) ? S_ISSUE : S_NEXT;
            end
`endif
            S_NEXT: begin
                ks_nx  = ks << 1;
                cnt_nx = cnt + CW'(1);
                op_nx  = '0;
                if (cnt_nx == CNT_END) begin
                    state_nx = S_DONE;
                    wout_nx  = ra;
                    zout_nx  = rb;
                end else begin
`ifdef BEC_CSWAP_EN
                    state_nx = S_SWIN;
`else
                    state_nx = S_ISSUE;
`endif
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Abort overrides every other event.
        if (abort) begin
            state_nx = S_IDLE;
            wout_nx  = '0;
            zout_nx  = '0;
        end

        busy_nx     = (state_nx != S_IDLE) && (state_nx != S_DONE);
        bit_done_nx = (state_nx == S_NEXT);
        done_nx     = (state_nx == S_DONE);
    end

    // Operand selection for the op about to be issued, from post-update state.
    always_comb begin
        {nx_x, nx_y, nx_u, nx_v} = to_roles(map_ki_nx, ra_nx, rb_nx, rc_nx, rd_nx);
        start_nx = (state_nx == S_ISSUE);
        a_nx     = acb_a;
        b_nx     = acb_b;
        cfg_nx   = acb_cfg;
        if (start_nx) begin
            cfg_nx = 1'b0;
            case (op_nx)
                3'd0: begin
                    a_nx = nx_x;
                    b_nx = nx_v;
                end
                3'd1: begin
                    a_nx = nx_y;
                    b_nx = nx_u;
                end
                3'd2: begin
                    a_nx = nx_y;
                    b_nx = nx_v;
                end
                3'd3: begin
                    a_nx   = inv_w0;
                    b_nx   = nx_x;
                    cfg_nx = 1'b1;
                end
                3'd4: begin
                    a_nx = nx_u;
                    b_nx = nx_u ^ nx_v;
                end
                3'd5: begin
                    a_nx = nx_v;
                    b_nx = nx_v;
                end
                default: begin
                    a_nx   = d;
                    b_nx   = nx_v;
                    cfg_nx = 1'b1;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks        <= '0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
            rd        <= '0;
            op        <= '0;
            cnt       <= '0;
            wout      <= '0;
            zout      <= '0;
            acb_start <= 1'b0;
            acb_a     <= '0;
            acb_b     <= '0;
            acb_cfg   <= 1'b0;
            busy      <= 1'b0;
            bit_done  <= 1'b0;
            done      <= 1'b0;
        end else begin
            ks        <= ks_nx;
            ra        <= ra_nx;
            rb        <= rb_nx;
            rc        <= rc_nx;
            rd        <= rd_nx;
            op        <= op_nx;
            cnt       <= cnt_nx;
            wout      <= wout_nx;
            zout      <= zout_nx;
            acb_start <= start_nx;
            acb_a     <= a_nx;
            acb_b     <= b_nx;
            acb_cfg   <= cfg_nx;
            busy      <= busy_nx;
            bit_done  <= bit_done_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_sm_bec_ladder.sv
// tb_sm_bec_ladder: directed bench for sm_bec_ladder with M=163, KEY_BITS=4 and
// a stub ACB of latency 3 (cfg0 = GF(2^163) multiply, cfg1 = a*b ^ b).
`timescale 1ns/1ps
module tb_sm_bec_ladder;

    localparam int M  = 163;
    localparam int KB = 4;
    localparam int L  = 3;
`ifdef BEC_CSWAP_EN
    localparam int BIT_CYC = 31;
`else
    localparam int BIT_CYC = 29;
`endif
    localparam int DONE_LAT = 1 + KB * BIT_CYC;
    localparam int OPS_RUN  = 7 * KB;

    logic          clk, rst, start, abort;
    logic [KB-1:0] k;
    logic [M-1:0]  w1, z1, w2, z2, inv_w0, d;
    logic          acb_start, acb_cfg, acb_done;
    logic [M-1:0]  acb_a, acb_b, acb_c;
    logic          busy, bit_done, done;
    logic [M-1:0]  wout, zout;

    logic [M-1:0]  p_w1, p_z1, p_w2, p_z2;
    logic          stub_done, inj_done;
    logic [M-1:0]  stub_c, pend_res;
    int            pend_cnt;
    int            n_chk, n_bad;

    sm_bec_ladder #(.M(M), .KEY_BITS(KB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .k(k),
        .w1(w1), .z1(z1), .w2(w2), .z2(z2), .inv_w0(inv_w0), .d(d),
        .acb_start(acb_start), .acb_a(acb_a), .acb_b(acb_b), .acb_cfg(acb_cfg),
        .acb_done(acb_done), .acb_c(acb_c),
        .busy(busy), .bit_done(bit_done), .done(done), .wout(wout), .zout(zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^163) multiply, reduction polynomial x^163 + x^7 + x^6 + x^3 + 1
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r, t, poly;
        r    = '0;
        t    = a;
        poly = M'(8'hC9);
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            if (t[M-1]) t = (t << 1) ^ poly;
            else        t = t << 1;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] cfg1(input logic [M-1:0] a, input logic [M-1:0] b);
        return gf_mul(a, b) ^ b;
    endfunction

    function automatic logic [M-1:0] rnd();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[M-1:0];
    endfunction

    // Golden ladder: returns {A, B} after all key bits.
    function automatic logic [2*M-1:0] ladder(input logic [KB-1:0] kk,
                                              input logic [M-1:0] pa, input logic [M-1:0] pb,
                                              input logic [M-1:0] pc, input logic [M-1:0] pd);
        logic [M-1:0] a, b, c, e, x, y, u, v, t;
        a = pa; b = pb; c = pc; e = pd;
        for (int i = KB - 1; i >= 0; i--) begin
            if (kk[i]) begin x = a; y = b; u = c; v = e; end
            else       begin x = c; y = e; u = a; v = b; end
            x = gf_mul(x, v);
            x = x ^ gf_mul(y, u);
            y = gf_mul(y, v);
            t = cfg1(inv_w0, x);
            x = x ^ t;
            y = y ^ t;
            u = gf_mul(u, u ^ v);
            v = gf_mul(v, v);
            v = u ^ cfg1(d, v);
            if (kk[i]) begin a = x; b = y; c = u; e = v; end
            else       begin c = x; e = y; a = u; b = v; end
        end
        return {a, b};
    endfunction

    // Stub ACB: acb_done L cycles after the acb_start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_done <= 1'b0;
            stub_c    <= '0;
            pend_res  <= '0;
            pend_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (pend_cnt == 1) begin
                stub_done <= 1'b1;
                stub_c    <= pend_res;
            end
            if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
            if (acb_start) begin
                pend_res <= acb_cfg ? cfg1(acb_a, acb_b) : gf_mul(acb_a, acb_b);
                pend_cnt <= L - 1;
            end
        end
    end

    assign acb_done = stub_done | inj_done;
    assign acb_c    = inj_done ? {M{1'b1}} : stub_c;

    task automatic chk(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // kind: 0 clean, 1 abort at ev_at, 2 stray start at ev_at + spurious done in ISSUE,
    //       3 reset in the first WAIT at/after ev_at
    task automatic run(input logic [KB-1:0] kk, input int kind, input int ev_at, input string tag);
        logic [2*M-1:0] gold;
        int  acb_n, bd_n, done_off;
        bit  fired, rst_pend, seen;
        gold     = ladder(kk, p_w1, p_z1, p_w2, p_z2);
        acb_n    = 0;
        bd_n     = 0;
        done_off = -1;
        fired    = 1'b0;
        rst_pend = 1'b0;
        @(negedge clk);
        k = kk; w1 = p_w1; z1 = p_z1; w2 = p_w2; z2 = p_z2;
        start = 1'b1;
        for (int off = 0; off <= 400; off++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; inj_done = 1'b0; k = kk; w1 = p_w1;
            if (rst_pend) begin
                rst = 1'b1;
                #1;
                chk({tag, "_rst_ctl"}, M'({acb_start, acb_cfg, busy, bit_done, done}), '0);
                chk({tag, "_rst_dat"}, acb_a | acb_b | wout | zout, '0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk({tag, "_rel_busy"}, M'(busy), '0);
                chk({tag, "_rel_acb"}, M'(acb_start), '0);
                return;
            end
            if (off == 0) chk({tag, "_busy_rise"}, M'(busy), M'(1));
            if (acb_start) acb_n++;
            if (bit_done) begin
                bd_n++;
                chk($sformatf("%s_bd%0d", tag, bd_n), M'(off), M'(bd_n * BIT_CYC));
            end
            if (done) begin
                done_off = off;
                break;
            end
            if (kind == 1 && off == ev_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk({tag, "_ab_busy"}, M'(busy), '0);
                chk({tag, "_ab_done"}, M'(done), '0);
                chk({tag, "_ab_wout"}, wout, '0);
                chk({tag, "_ab_zout"}, zout, '0);
                seen = 1'b0;
                repeat (150) begin
                    @(negedge clk);
                    if (done || busy) seen = 1'b1;
                end
                chk({tag, "_ab_quiet"}, M'(seen), '0);
                return;
            end
            if (kind == 2) begin
                if (off == ev_at) begin
                    start = 1'b1;
                    k     = ~kk;
                    w1    = ~p_w1;
                end
                if (off >= ev_at + 10 && acb_start && !fired) begin
                    inj_done = 1'b1;
                    fired    = 1'b1;
                end
            end
            if (kind == 3 && off >= ev_at && acb_start && !fired) begin
                fired    = 1'b1;
                rst_pend = 1'b1;
            end
        end
        chk({tag, "_done_lat"}, M'(done_off), M'(DONE_LAT));
        chk({tag, "_acb_n"}, M'(acb_n), M'(OPS_RUN));
        chk({tag, "_bd_n"}, M'(bd_n), M'(KB));
        chk({tag, "_wout"}, wout, gold[2*M-1:M]);
        chk({tag, "_zout"}, zout, gold[M-1:0]);
        chk({tag, "_busy_done"}, M'(busy), '0);
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, M'(done), '0);
        chk({tag, "_start_ign"}, M'(busy), '0);
        chk({tag, "_hold"}, wout, gold[2*M-1:M]);
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        inj_done = 1'b0;
        k        = '0;
        w1 = '0; z1 = '0; w2 = '0; z2 = '0; inv_w0 = '0; d = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", M'({acb_start, acb_cfg, busy, bit_done, done}), '0);
        chk("reset_dat", acb_a | acb_b | wout | zout, '0);
        rst = 1'b0;
        p_w1 = rnd(); p_z1 = rnd(); p_w2 = rnd(); p_z2 = rnd();
        inv_w0 = rnd(); d = rnd();

        run(4'b1011, 0, 0,  "s1");
        run(4'b0000, 0, 0,  "s2_k0");
        run(4'b1111, 0, 0,  "s2_kf");
        run(4'b1011, 1, 40, "s3_abort");
        run(4'b0110, 0, 0,  "s3_after");
        run(4'b1011, 2, 10, "s4_noise");
        run(4'b1011, 3, 50, "s5_rst");
        run(4'b1011, 0, 0,  "s5_after");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_bec_ladder.md
# sm_bec_ladder

Parametrised Montgomery-ladder sequencer for binary Edwards curve scalar multiplication over GF(2^M). It loads a full scalar, walks it MSB-first, and issues seven field operations per key bit to an external arithmetic computation block (ACB) over a start/done handshake. It keeps the projective ladder state (A,B,C,D) in internal registers and returns (wout,zout) = (A,B) after the last bit. It sits between the user-area control interface and the shared ACB.

## Interface
- M, 163, field width in bits
- KEY_BITS, 163, scalar bits processed (1..255)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  begin multiplication; sampled only in IDLE
- abort  in  1  return to IDLE next cycle from any state
- k  in  KEY_BITS  scalar, captured on accepted start
- w1, z1, w2, z2  in  M each  initial ladder points, captured on start
- inv_w0, d  in  M each  curve constants, must stay stable while busy
- acb_start  out  1  one-cycle operation request
- acb_a, acb_b  out  M each  ACB operands, valid with acb_start
- acb_cfg  out  1  ACB mode (0 = multiply, 1 = mode 1)
- acb_done  in  1  result valid on acb_c this cycle
- acb_c  in  M  ACB result
- busy  out  1  high from LOAD through the last bit
- bit_done  out  1  one-cycle pulse per completed key bit
- done  out  1  one-cycle pulse on completion
- wout, zout  out  M each  result, held from DONE until the next accepted start or abort

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, NEXT, DONE. The BEC_CSWAP_EN build adds SWIN and SWOUT.
- IDLE:
  - start=1 captures k into a shift register and w1,z1,w2,z2 into A,B,C,D, then goes to LOAD.
  - LOAD clears op index and bit counter, then goes to ISSUE.
- Key bit ki is the current MSB of the shift register.
- Role mapping, default build:
  - ki=1: X=A, Y=B, U=C, V=D.
  - ki=0: X=C, Y=D, U=A, V=B.
- Operation schedule (op index 0..6):
  - op0, cfg0: X <= X·V
  - op1, cfg0: X <= X ^ Y·U
  - op2, cfg0: Y <= Y·V
  - op3, cfg1, operands (inv_w0, X): t = result; X <= X^t and Y <= Y^t in the same cycle
  - op4, cfg0: U <= U·(U^V)
  - op5, cfg0: V <= V·V
  - op6, cfg1, operands (d, V): V <= U ^ result
- ISSUE: drives acb_start=1 with registered operands and acb_cfg for one cycle, then goes to WAIT.
- WAIT: on acb_done=1, writes acb_c back per the schedule at that clock edge.
  - op<6: increment op index, go to ISSUE.
  - op=6: go to NEXT.
- NEXT: shift k left, increment bit counter, pulse bit_done.
  - If counter reaches KEY_BITS, go to DONE and latch wout=A, zout=B.
  - Otherwise go to ISSUE with op index 0.
- DONE: pulse done for one cycle, then go to IDLE.
- acb_done outside WAIT is ignored. start outside IDLE is ignored.
- abort=1 wins over all other events: next state IDLE, no done pulse, wout/zout cleared.
  - The block does not cancel the ACB; a late acb_done is ignored.
- Reset values:
  - state IDLE
  - A..D, wout, zout, acb_a, acb_b = 0
  - acb_start, acb_cfg, busy, bit_done, done = 0
- Bit counter width: $clog2(KEY_BITS+1). No wrap: a counter equal to KEY_BITS always terminates.

## Timing
- Let L be the ACB latency in cycles from the acb_start cycle to the acb_done cycle.
- One operation takes L+1 cycles.
- One key bit takes 7(L+1)+1 cycles (BEC_CSWAP_EN build: 7(L+1)+3).
- done asserts 1 + KEY_BITS·(bit cycles) cycles after the edge that samples start.
- busy goes high the cycle after start is sampled and goes low in DONE.
- start asserted in the DONE cycle is ignored.
- Back-to-back runs are possible from IDLE one cycle after done.

## Configuration
- BEC_CSWAP_EN defined: constant-time datapath.
  - SWIN: if ki=0, swap (A,B)<->(C,D) using a mask-XOR, not a mux select.
  - The fixed mapping X=A, Y=B, U=C, V=D is then used for all ops.
  - SWOUT repeats the swap with the same ki.
  - Operand selection is independent of ki; each SW state is one cycle.
- BEC_CSWAP_EN undefined: ki-dependent role mapping as above, no SW states.
- Results are identical in both builds.

## Test plan
- Setup for all scenarios: M=163, KEY_BITS=4, stub ACB with L=3 and GF(2^163) multiply (cfg0) plus a reference cfg1 model.
- Scenario 1, k=4'b1011, random points: done at cycle 117 after start (125 with BEC_CSWAP_EN); wout/zout match the golden ladder model; 4 bit_done pulses at 29-cycle spacing.
- Scenario 2, k=4'b0000 and k=4'b1111: correct results; acb_start count = 28 per run.
- Scenario 3, abort at cycle 40: IDLE next cycle, busy=0, no done pulse, wout=zout=0; a subsequent start with k=4'b0110 completes correctly.
- Scenario 4, start pulsed while busy, plus a spurious acb_done in ISSUE: both ignored; result unchanged versus the clean run.
- Scenario 5, rst asserted mid-WAIT: all outputs zero immediately; state IDLE on release.
